// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-byte holding register.
// Define UART_RX_PARITY_EN to expect an even-parity bit after bit 7.
module uart_rx #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);

  localparam logic [CW-1:0] C_HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] C_BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_prev;
  logic [1:0]    r_flush;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_ferr;
  logic          r_ovr;

  logic w_fall;
  logic w_half_tick;
  logic w_bit_tick;
  logic w_cnt_clr;
  logic w_shift_en;
  logic w_stop_smp;
  logic w_par_err;
  logic w_load;
  logic w_ferr;

`ifdef UART_RX_PARITY_EN
  logic r_par_err;
  logic w_par_en;
`endif

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;

  // Two-flop synchronizer; idles high so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // Edge history, trusted only once the forced reset ones have flushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev  <= 1'b0;
      r_flush <= 2'd0;
    end else begin
      r_prev <= r_sync2;
      if (r_flush != 2'd3)
        r_flush <= r_flush + 2'd1;
    end
  end

  assign w_fall = (r_flush == 2'd3)
                & r_prev & ~r_sync2;

  assign w_half_tick = (r_cnt == C_HALF_LAST);
  assign w_bit_tick  = (r_cnt == C_BIT_LAST);

`ifdef UART_RX_PARITY_EN
  assign w_par_err = r_par_err;
`else
  assign w_par_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_fall)
          w_next = S_START;
      S_START:
        if (w_half_tick)
          w_next = r_sync2 ? S_IDLE : S_DATA;
      S_DATA:
        if (w_bit_tick && r_bitcnt == 3'd7)
`ifdef UART_RX_PARITY_EN
          w_next = S_PARITY;
`else
          w_next = S_STOP;
`endif
`ifdef UART_RX_PARITY_EN
      S_PARITY:
        if (w_bit_tick)
          w_next = S_STOP;
`endif
      S_STOP:
        if (w_bit_tick)
          w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  // Per-state strobes for the datapath.
  always_comb begin
    w_cnt_clr  = 1'b0;
    w_shift_en = 1'b0;
    w_stop_smp = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_en   = 1'b0;
`endif
    unique case (r_state)
      S_IDLE:  w_cnt_clr = 1'b1;
      S_START: w_cnt_clr = w_half_tick;
      S_DATA: begin
        w_cnt_clr  = w_bit_tick;
        w_shift_en = w_bit_tick;
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        w_cnt_clr = w_bit_tick;
        w_par_en  = w_bit_tick;
      end
`endif
      S_STOP: begin
        w_cnt_clr  = w_bit_tick;
        w_stop_smp = w_bit_tick;
      end
      default: w_cnt_clr = 1'b1;
    endcase
  end

  assign w_load = w_stop_smp & r_sync2
                & ~w_par_err;
  assign w_ferr = w_stop_smp
                & (~r_sync2 | w_par_err);

  // Bit timing counter, bit index and LSB-first shifter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_bitcnt <= 3'd0;
      r_shift  <= 8'h00;
    end else begin
      if (w_cnt_clr)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CW'(1);
      if (r_state == S_IDLE)
        r_bitcnt <= 3'd0;
      else if (w_shift_en)
        r_bitcnt <= r_bitcnt + 3'd1;
      if (w_shift_en)
        r_shift <= {r_sync2, r_shift[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: data bits plus parity bit must XOR to zero.
  always_ff @(posedge clk) begin
    if (rst)
      r_par_err <= 1'b0;
    else if (r_state == S_IDLE)
      r_par_err <= 1'b0;
    else if (w_par_en)
      r_par_err <= (^r_shift) ^ r_sync2;
  end
`endif

  // Holding register, handshake and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      r_ovr  <= 1'b0;
      if (w_load) begin
        if (!r_valid || rx_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames at 10 clk/bit, scoreboard on handshakes.
// Build with UART_RX_PARITY_EN to exercise the parity variant.
module tb_uart_rx;

  localparam int CPB = 10;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int STOP_OFF = CPB * (NBITS - 1);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_valid = 0, n_ferr = 0, n_ovr = 0, n_hs = 0;
  int b_valid, b_ferr, b_ovr, b_hs;
  int rise_cyc = -1;
  int tx_start = 0;
  logic prev_v = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx #(
    .CLK_FREQ(1000000),
    .BAUD(100000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Monitor: counts pulses and pops the scoreboard on each handshake.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst) begin
      if (rx_valid) n_valid++;
      if (rx_valid && !prev_v) rise_cyc = cyc;
      if (frame_err) n_ferr++;
      if (overrun) n_ovr++;
      if (rx_valid && rx_ready) begin
        n_hs++;
        e = (exp_q.size() > 0) ? {24'h0, exp_q.pop_front()} : 32'h100;
        check("rx_data", {24'h0, rx_data}, e);
      end
    end
    prev_v = rx_valid;
  end

  task automatic snap();
    b_valid = n_valid;
    b_ferr  = n_ferr;
    b_ovr   = n_ovr;
    b_hs    = n_hs;
  endtask

  task automatic put_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b,
                      input logic stop_bit,
                      input logic par_flip);
    tx_start = cyc;
    put_bit(1'b0);
    for (int i = 0; i < 8; i++) put_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    put_bit((^b) ^ par_flip);
`endif
    put_bit(stop_bit);
  endtask

  initial begin
    int d;
    // Reset with the line held low; it must not start a frame later.
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 8'h00);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    rst = 1'b0;
    snap();
    repeat (30) @(posedge clk);
    #1;
    idle(120);
    check("low_after_rst_valid", n_valid - b_valid, 0);
    check("low_after_rst_ferr", n_ferr - b_ferr, 0);

    // Single byte, consumer always ready.
    snap();
    exp_q.push_back(8'h55);
    send(8'h55, 1'b1, 1'b0);
    d = rise_cyc - tx_start;
    idle(5);
    check("b55_hs", n_hs - b_hs, 1);
    check("b55_valid_cycles", n_valid - b_valid, 1);
    check("b55_in_stop_bit", (d > STOP_OFF) && (d <= STOP_OFF + CPB), 1);
    check("b55_ferr", n_ferr - b_ferr, 0);

    // Back-to-back frames with no idle gap.
    snap();
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    send(8'h0D, 1'b1, 1'b0);
    send(8'h0A, 1'b1, 1'b0);
    idle(5);
    check("b2b_hs", n_hs - b_hs, 2);
    check("b2b_ferr", n_ferr - b_ferr, 0);
    check("b2b_ovr", n_ovr - b_ovr, 0);

    // Glitch shorter than half a bit is a false start.
    snap();
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(30);
    check("false_start_valid", n_valid - b_valid, 0);
    check("false_start_ferr", n_ferr - b_ferr, 0);
    snap();
    exp_q.push_back(8'hA3);
    send(8'hA3, 1'b1, 1'b0);
    idle(5);
    check("bA3_hs", n_hs - b_hs, 1);

    // Stop bit driven low.
    snap();
    send(8'h41, 1'b0, 1'b0);
    idle(20);
    check("b41_ferr", n_ferr - b_ferr, 1);
    check("b41_valid", n_valid - b_valid, 0);
    check("b41_data_kept", rx_data, 8'hA3);
    snap();
    exp_q.push_back(8'h42);
    send(8'h42, 1'b1, 1'b0);
    idle(5);
    check("b42_hs", n_hs - b_hs, 1);

    // Overrun: second byte lands while the first is unconsumed.
    rx_ready = 1'b0;
    snap();
    exp_q.push_back(8'h11);
    send(8'h11, 1'b1, 1'b0);
    idle(5);
    send(8'h22, 1'b1, 1'b0);
    idle(5);
    check("ovr_pulse", n_ovr - b_ovr, 1);
    check("ovr_valid_held", rx_valid, 1);
    check("ovr_data_kept", rx_data, 8'h11);
    check("ovr_no_hs", n_hs - b_hs, 0);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ovr_hs", n_hs - b_hs, 1);
    check("ovr_valid_clear", rx_valid, 0);

    // Reset in the middle of bit 4 of 0xFF.
    snap();
    tx_start = cyc;
    put_bit(1'b0);
    for (int i = 0; i < 4; i++) put_bit(1'b1);
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(150);
    check("rst_mid_valid", n_valid - b_valid, 0);
    check("rst_mid_ferr", n_ferr - b_ferr, 0);
    check("rst_mid_rxvalid", rx_valid, 0);
    snap();
    exp_q.push_back(8'h3C);
    send(8'h3C, 1'b1, 1'b0);
    idle(5);
    check("b3C_hs", n_hs - b_hs, 1);
`ifdef UART_RX_PARITY_EN
    snap();
    send(8'h3C, 1'b1, 1'b1);
    idle(20);
    check("par_ferr", n_ferr - b_ferr, 1);
    check("par_valid", n_valid - b_valid, 0);
`endif

    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
